// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcodes, flag
// bit positions and controller states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NOT  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_EQ   = 4'd7,
    OP_MUL  = 4'd8,
    OP_DIVU = 4'd9,
    OP_REMU = 4'd10,
    OP_SLL  = 4'd11,
    OP_SRL  = 4'd12,
    OP_SRA  = 4'd13
  } op_e;

  localparam int F_ZERO  = 0;
  localparam int F_NEG   = 1;
  localparam int F_CARRY = 2;
  localparam int F_OVF   = 3;
  localparam int F_DZ    = 4;
  localparam int F_ERR   = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial datapath: shift-add multiply and
// restoring divide, one step per cycle for WIDTH cycles.
module alu_iter_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] hi_res
);
  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lo, hi, x, y;
  logic [WIDTH-1:0] n_lo, n_hi;
  logic [WIDTH:0]   tmp, diff;
  logic             ge;

  assign done = busy && (cnt == CW'(WIDTH - 1));
  assign quo = n_lo;
  assign hi_res = n_hi;

  // hi is the partial remainder (divide) or accumulator (multiply)
  always_comb begin
    tmp  = {hi, lo[WIDTH-1]};
    diff = tmp - {1'b0, x};
    ge   = ~diff[WIDTH];
    n_lo = lo;
    n_hi = hi + (y[0] ? x : '0);
    if (div_q) begin
      n_lo = {lo[WIDTH-2:0], ge};
      n_hi = ge ? diff[WIDTH-1:0] : tmp[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      lo    <= '0;
      hi    <= '0;
      x     <= '0;
      y     <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= div;
      cnt   <= '0;
      lo    <= a;
      hi    <= '0;
      x     <= div ? b : a;
      y     <= b;
    end else if (busy) begin
      lo  <= n_lo;
      hi  <= n_hi;
      y   <= y >> 1;
      cnt <= cnt + CW'(1);
      if (!div_q) x <= x << 1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// ALU with valid/ready handshake; single-cycle logic ops,
// iterative multiply/divide via alu_iter_unit.
module iter_alu #(
  parameter int WIDTH = 4,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [5:0]       out_flags
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] WL = WIDTH[WIDTH-1:0];

  state_e           state, nxt;
  logic [OPW-1:0]   op_q;
  logic             dz_q;
  logic             accept, multi;
  logic [WIDTH-1:0] sh, s_res, m_res;
  logic [WIDTH:0]   sum;
  logic [5:0]       s_fl, m_fl;
  logic             u_done;
  logic [WIDTH-1:0] u_quo, u_hi;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign multi     = (in_op == OP_MUL) ||
                     (in_op == OP_DIVU) ||
                     (in_op == OP_REMU);

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && multi),
    .div    (in_op != OP_MUL),
    .a      (in_a),
    .b      (in_b),
    .done   (u_done),
    .quo    (u_quo),
    .hi_res (u_hi)
  );

  always_comb begin
    s_res = '0;
    s_fl  = '0;
    sum   = '0;
    sh    = in_b % WL;
    case (in_op)
      OP_ADD: begin
        sum = {1'b0, in_a} + {1'b0, in_b};
        s_res = sum[MSB:0];
        s_fl[F_CARRY] = sum[WIDTH];
        s_fl[F_OVF] = (in_a[MSB] == in_b[MSB]) &&
                      (s_res[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        sum = {1'b0, in_a} + {1'b0, ~in_b} +
              (WIDTH+1)'(1);
        s_res = sum[MSB:0];
        s_fl[F_CARRY] = sum[WIDTH];
        s_fl[F_OVF] = (in_a[MSB] != in_b[MSB]) &&
                      (s_res[MSB] != in_a[MSB]);
      end
      OP_NOT: s_res = ~in_a;
      OP_AND: s_res = in_a & in_b;
      OP_OR:  s_res = in_a | in_b;
      OP_XOR: s_res = in_a ^ in_b;
      OP_SLT: s_res = {{(WIDTH-1){1'b0}},
                       $signed(in_a) < $signed(in_b)};
      OP_EQ:  s_res = {{(WIDTH-1){1'b0}},
                       in_a == in_b};
      OP_SLL: s_res = in_a << sh;
      OP_SRL: s_res = in_a >> sh;
      OP_SRA: s_res = $signed(in_a) >>> sh;
      default: ;
    endcase
    if (in_op > OPW'(OP_SRA)) begin
      s_fl[F_ERR] = 1'b1;
    end else begin
      s_fl[F_ZERO] = (s_res == '0);
      s_fl[F_NEG]  = s_res[MSB];
    end
  end

  always_comb begin
    m_res = (op_q == OP_DIVU) ? u_quo : u_hi;
    m_fl = '0;
    m_fl[F_ZERO] = (m_res == '0);
    m_fl[F_NEG]  = m_res[MSB];
    m_fl[F_DZ]   = dz_q;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (in_valid) nxt = multi ? S_BUSY : S_DONE;
      S_BUSY:
        if (u_done) nxt = S_DONE;
      S_DONE:
        if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      dz_q      <= 1'b0;
      out_res   <= '0;
      out_flags <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_q <= in_op;
        dz_q <= (in_b == '0) && (in_op != OP_MUL);
        if (!multi) begin
          out_res   <= s_res;
          out_flags <= s_fl;
        end
      end
      if (state == S_BUSY && u_done) begin
        out_res   <= m_res;
        out_flags <= m_fl;
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu (WIDTH=4): vector table, random
// ops against a reference model, handshake/reset cases.
module tb_iter_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_res;
  logic [5:0] out_flags;

  int n_chk = 0;
  int n_fail = 0;

  iter_alu #(.WIDTH(4), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [5:0] fl;
    int         lat;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // flags packed as {err,dz,ovf,carry,neg,zero}
  function automatic logic [9:0] model(
      input int op, input int a, input int b);
    int sa, sb, r, s, sh;
    logic c, o, dz, err;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    sh = b % 4;
    r = 0; c = 0; o = 0; dz = 0; err = 0;
    case (op)
      0: begin
        r = (a + b) % 16; c = (a + b) > 15;
        o = (sa + sb > 7) || (sa + sb < -8);
      end
      1: begin
        r = (a - b + 16) % 16; c = (a >= b);
        o = (sa - sb > 7) || (sa - sb < -8);
      end
      2: r = 15 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = (sa < sb) ? 1 : 0;
      7: r = (a == b) ? 1 : 0;
      8: r = (a * b) % 16;
      9: begin r = (b == 0) ? 15 : a / b; dz = (b == 0); end
      10: begin r = (b == 0) ? a : a % b; dz = (b == 0); end
      11: r = (a * (1 << sh)) % 16;
      12: r = a / (1 << sh);
      13: r = (sa >>> sh) & 15;
      default: err = 1;
    endcase
    return {err, dz, o, c,
            !err && (r >= 8), !err && (r == 0),
            r[3:0]};
  endfunction

  task automatic run(input logic [3:0] op,
                     input logic [3:0] a,
                     input logic [3:0] b,
                     output logic [3:0] res,
                     output logic [5:0] fl,
                     output int lat,
                     output int rdy);
    int n;
    n = 0;
    rdy = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'($urandom);
    in_a = 4'($urandom);
    in_b = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy = 1;
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_res;
    fl = out_flags;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic [5:0] f;
    logic [9:0] m;
    int lat, rdy, seen;
    logic [3:0] op, a, b;

    tbl[0]  = '{4'd0,  4'd7,  4'd1, 4'h8, 6'b001010, 1};
    tbl[1]  = '{4'd1,  4'd0,  4'd1, 4'hF, 6'b000010, 1};
    tbl[2]  = '{4'd6,  4'd8,  4'd1, 4'h1, 6'b000000, 1};
    tbl[3]  = '{4'd8,  4'd5,  4'd3, 4'hF, 6'b000010, 5};
    tbl[4]  = '{4'd9,  4'd13, 4'd4, 4'h3, 6'b000000, 5};
    tbl[5]  = '{4'd10, 4'd13, 4'd4, 4'h1, 6'b000000, 5};
    tbl[6]  = '{4'd9,  4'd9,  4'd0, 4'hF, 6'b010010, 5};
    tbl[7]  = '{4'd10, 4'd9,  4'd0, 4'h9, 6'b010010, 5};
    tbl[8]  = '{4'd15, 4'd6,  4'd3, 4'h0, 6'b100000, 1};
    tbl[9]  = '{4'd14, 4'd1,  4'd1, 4'h0, 6'b100000, 1};
    tbl[10] = '{4'd0,  4'hF,  4'd1, 4'h0, 6'b000101, 1};
    tbl[11] = '{4'd1,  4'd8,  4'd1, 4'h7, 6'b001100, 1};
    tbl[12] = '{4'd13, 4'd8,  4'd1, 4'hC, 6'b000010, 1};
    tbl[13] = '{4'd11, 4'd3,  4'd6, 4'hC, 6'b000010, 1};
    tbl[14] = '{4'd8,  4'd0,  4'd7, 4'h0, 6'b000001, 5};
    tbl[15] = '{4'd7,  4'd5,  4'd5, 4'h1, 6'b000000, 1};

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_res", int'(out_res), 0);
    chk("rst_out_flags", int'(out_flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, r, f, lat, rdy);
      chk($sformatf("vec%0d_res", i), int'(r),
          int'(tbl[i].res));
      chk($sformatf("vec%0d_flags", i), int'(f),
          int'(tbl[i].fl));
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_busy_rdy", i), rdy, 0);
    end

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 4'($urandom);
      b = 4'($urandom);
      m = model(int'(op), int'(a), int'(b));
      run(op, a, b, r, f, lat, rdy);
      chk($sformatf("rnd%0d_op%0d_res", i, op),
          int'(r), int'(m[3:0]));
      chk($sformatf("rnd%0d_op%0d_flags", i, op),
          int'(f), int'(m[9:4]));
      chk($sformatf("rnd%0d_op%0d_lat", i, op), lat,
          (op >= 8 && op <= 10) ? 5 : 1);
    end

    // back-pressure: ADD 2+2 held, next request waits
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 4'd0;
    in_a = 4'd2;
    in_b = 4'd2;
    @(posedge clk);
    #1;
    in_a = 4'd1;
    in_b = 4'd1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("bp%0d_res", k), int'(out_res), 4);
      chk($sformatf("bp%0d_ready", k), int'(in_ready), 0);
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_hs_valid", int'(out_valid), 0);
    chk("bp_hs_ready", int'(in_ready), 1);
    chk("bp_hs_hold", int'(out_res), 4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_res", int'(out_res), 2);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // reset in the second BUSY cycle of MUL 5*3
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 4'd8;
    in_a = 4'd5;
    in_b = 4'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mr_busy_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_res", int'(out_res), 0);
    chk("mr_flags", int'(out_flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_ready", int'(in_ready), 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("mr_no_stale", seen, 0);
    run(4'd15, 4'd3, 4'd2, r, f, lat, rdy);
    chk("mr_ill_res", int'(r), 0);
    chk("mr_ill_flags", int'(f), 6'b100000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal range 2..32.
REQ-002 Parameter: OPW, default 4, opcode width; fixed at 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_op  input  OPW  operation code.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_res  output  WIDTH  result.
REQ-013 out_flags  output  6  {err, dz, ovf, carry, neg, zero}.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 NOT(a), 3 AND, 4 OR, 5 XOR, 6 SLT (signed a<b -> 1 else 0), 7 EQ (a==b -> 1 else 0), 8 MUL (unsigned, low WIDTH bits), 9 DIVU (quotient), 10 REMU (remainder), 11 SLL, 12 SRL, 13 SRA; 14-15 illegal.
REQ-015 Shift amount SHALL be in_b modulo WIDTH (low clog2(WIDTH) bits only when WIDTH is a power of two, in_b % WIDTH otherwise).
REQ-016 ADD: {carry,res}=a+b; SUB: {carry,res}=a+~b+1 (carry=0 means borrow); ovf SHALL be signed overflow for ADD/SUB only.
REQ-017 zero SHALL be (res==0); neg SHALL be res[WIDTH-1]; carry/ovf SHALL be 0 for all ops other than ADD/SUB.
REQ-018 Illegal opcode: res=0, err=1, zero=0, all other flags 0, single-cycle latency.
REQ-019 Divide by zero: DIVU res all-ones, REMU res=a, dz=1; full multi-cycle latency still applies.
REQ-020 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-021 Accept = in_valid & in_ready at a rising edge; operands and opcode SHALL be captured then; later input changes ignored.
REQ-022 Single-cycle ops (0-7, 11-13, illegal): IDLE -> DONE on accept; out_valid high the cycle after accept.
REQ-023 Multi-cycle ops (8-10): IDLE -> BUSY on accept; BUSY SHALL last exactly WIDTH cycles (one shift-add / restoring-subtract step per cycle), then DONE; out_valid high WIDTH+1 cycles after accept edge.
REQ-024 DONE: out_valid=1, out_res/out_flags stable; on out_valid & out_ready edge -> IDLE.
REQ-025 out_valid SHALL remain high and out_res/out_flags SHALL not change while out_ready=0 (back-pressure, unbounded).
REQ-026 out_valid=0 in IDLE and BUSY; out_res/out_flags hold the last delivered values outside DONE.
REQ-027 No request overlap: a new request is accepted at earliest the cycle after the DONE handshake.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, out_valid=0, out_res=0, out_flags=0, iteration counter=0, operand registers=0.
REQ-029 Reset during BUSY or DONE SHALL abandon the operation; no result is delivered.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum, flag-bit index constants and the FSM state typedef.
REQ-032 Sub-module alu_iter_unit SHALL implement the iterative multiply and restoring divide datapath (start, done, WIDTH-cycle counter); top holds FSM, handshake and single-cycle ops.

Verification (WIDTH=4)
REQ-033 ADD a=7,b=1 -> res=0x8, neg=1, ovf=1, carry=0, out_valid 1 cycle after accept.
REQ-034 SUB a=0,b=1 -> res=0xF, carry=0, neg=1, ovf=0; SLT a=0x8,b=0x1 -> res=1.
REQ-035 MUL a=5,b=3 -> res=0xF, out_valid exactly 5 cycles after accept, in_ready=0 throughout.
REQ-036 DIVU 13/4 -> res=3; REMU 13/4 -> res=1; DIVU 9/0 -> res=0xF, dz=1.
REQ-037 Hold out_ready=0 for 3 cycles after ADD 2+2 -> out_res=4 stable, out_valid high, in_ready=0; new request accepted only after handshake.
REQ-038 Assert rst_n=0 in 2nd BUSY cycle of MUL -> out_valid=0 immediately, in_ready=1 after release, no stale result; opcode 15 -> res=0, err=1.
